// File: rtl/fifo_serial_tx_pkg.sv
// Shared types and constants for the FIFO-fed serial transmitter.
// Parity support is selected with the FIFO_SERIAL_TX_PARITY_EN macro.
package fifo_serial_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    localparam int   CLK_DIV_DEFAULT = 16;
    localparam logic TX_IDLE         = 1'b1;

    // Width of the bit-timer down-counter, $clog2(CLK_DIV), never less than one bit.
    function automatic int timer_w(input int clk_div);
        return (clk_div > 2) ? $clog2(clk_div) : 1;
    endfunction

endpackage

// File: rtl/fifo_serial_tx_bit_timer.sv
// CLK_DIV down-counter pacing one serial bit; tick is high while the count is zero.
// Loading restarts a full bit period of exactly CLK_DIV cycles.
module bit_timer
    import fifo_serial_tx_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tick
);

    localparam int            TW     = timer_w(CLK_DIV);
    localparam logic [TW-1:0] RELOAD = TW'(CLK_DIV - 1);

    logic [TW-1:0] count;

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // flop samples the pre-edge values of its neighbours regardless of process order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops words from the channel-data FIFO and sends each as a UART frame on tx.
// Define FIFO_SERIAL_TX_PARITY_EN to append an even-parity bit after the data bits.
module fifo_serial_tx
    import fifo_serial_tx_pkg::*;
#(
    parameter int WBITS     = 8,
    parameter int CLK_DIV   = CLK_DIV_DEFAULT,
    parameter int STOP_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             fifo_empty,
    input  logic [WBITS-1:0] fifo_data,
    output logic             fifo_rd,
    output logic             tx,
    output logic             busy,
    output logic [15:0]      words_sent
);

    localparam int            IW        = $clog2(WBITS + 1);
    localparam logic [IW-1:0] LAST_DATA = IW'(WBITS - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

    state_t           state, state_nxt;
    logic [WBITS-1:0] shreg, shreg_nxt;
    logic [IW-1:0]    bit_idx, bit_idx_nxt;
    logic             tick;
    logic             timer_load;
    logic             frame_done;
    logic             fifo_rd_nxt;
    logic             tx_nxt;
    logic             busy_nxt;
`ifdef FIFO_SERIAL_TX_PARITY_EN
    logic             parity_bit;
`endif

    bit_timer #(.CLK_DIV(CLK_DIV)) u_bit_timer (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load),
        .tick (tick)
    );

    // NOTE: every signal driven here gets a default first, so no path can leave one
    // unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_idx_nxt = bit_idx;
        timer_load  = 1'b0;
        frame_done  = 1'b0;

        case (state)
            IDLE: begin
                if (en && !fifo_empty) state_nxt = POP;
            end
            POP: begin
                state_nxt = LOAD;
            end
            LOAD: begin
                shreg_nxt  = fifo_data;
                timer_load = 1'b1;
                state_nxt  = START;
            end
            START: begin
                if (tick) begin
                    timer_load = 1'b1;
                    state_nxt  = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    timer_load = 1'b1;
                    if (bit_idx == LAST_DATA) begin
                        bit_idx_nxt = '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
                        state_nxt   = PARITY;
`else
                        state_nxt   = STOP;
`endif
                    end else begin
                        bit_idx_nxt = bit_idx + 1'b1;
                        shreg_nxt   = shreg >> 1;
                    end
                end
            end
`ifdef FIFO_SERIAL_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    timer_load = 1'b1;
                    state_nxt  = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    timer_load = 1'b1;
                    if (bit_idx == LAST_STOP) begin
                        bit_idx_nxt = '0;
                        frame_done  = 1'b1;
                        state_nxt   = IDLE;
                    end else begin
                        bit_idx_nxt = bit_idx + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Outputs are decoded from the next state so the registered copies line up
        // with the state they belong to.
        fifo_rd_nxt = (state_nxt == POP);
        busy_nxt    = (state_nxt != IDLE);
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shreg_nxt[0];
`ifdef FIFO_SERIAL_TX_PARITY_EN
            PARITY:  tx_nxt = parity_bit;
`endif
            default: tx_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_idx    <= '0;
            fifo_rd    <= 1'b0;
            tx         <= TX_IDLE;
            busy       <= 1'b0;
            words_sent <= '0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_idx <= bit_idx_nxt;
            fifo_rd <= fifo_rd_nxt;
            tx      <= tx_nxt;
            busy    <= busy_nxt;
            if (frame_done) words_sent <= words_sent + 1'b1;
        end
    end

`ifdef FIFO_SERIAL_TX_PARITY_EN
    // The shift register is consumed during DATA, so parity is taken from the word at load time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_bit <= 1'b0;
        end else if (state == LOAD) begin
            parity_bit <= ^fifo_data;
        end
    end
`endif

endmodule
